// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES block type, permutation modes and IP / IP^-1 index functions.
package des_pkg;

    typedef logic [0:63] des_block_t;

    typedef enum logic [1:0] {
        PM_BYPASS = 2'b00,
        PM_IP     = 2'b01,
        PM_IPINV  = 2'b10,
        PM_RSVD   = 2'b11
    } perm_mode_e;

    // Index i = 8r+c in [0:63] order; bit 0 is DES bit 1.
    function automatic des_block_t des_ip(input des_block_t x);
        des_block_t y;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                y[8*r+c] = x[8*(7-c) + ((r < 4) ? (2*r + 1) : (2*(r-4)))];
            end
        end
        return y;
    endfunction

    function automatic des_block_t des_ip_inv(input des_block_t x);
        des_block_t y;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                y[8*r+c] = x[8*(c >> 1) + ((c % 2 == 1) ? 7 : 39) - r];
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/des_perm_stage.sv
// rtl/des_perm_stage.sv - one valid/ready register slice with synchronous flush.
module des_perm_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    // Loads when empty or when the held beat leaves this cycle, so bubbles collapse.
    assign s_ready = !m_valid || m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            if (flush) begin
                m_valid <= 1'b0;
            end else if (s_ready) begin
                m_valid <= s_valid;
            end
            if (s_ready && s_valid && !flush) begin
                m_data <= s_data;
            end
        end
    end

endmodule

// File: rtl/des_perm_pipe.sv
// rtl/des_perm_pipe.sv - pipelined DES IP / IP^-1 / bypass unit with tag sideband and flush.
// Defining DES_PERM_PARITY_EN adds the registered per-byte odd-parity output out_par.
module des_perm_pipe
    import des_pkg::*;
#(
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:63]      in_data,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:63]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
`ifdef DES_PERM_PARITY_EN
    ,
    output logic [0:7]       out_par
`endif
);

`ifdef DES_PERM_PARITY_EN
    localparam int PW = 64 + 1 + TAG_W + 8;
`else
    localparam int PW = 64 + 1 + TAG_W;
`endif

    des_block_t perm_data;
    logic       err_in;
    logic [PW-1:0] pay [0:PIPE_STAGES];
    logic [PIPE_STAGES:0] v;
    logic [PIPE_STAGES:0] rdy;

    always_comb begin
        perm_data = in_data;
        err_in    = 1'b0;
        case (perm_mode_e'(in_mode))
            PM_IP:    perm_data = des_ip(in_data);
            PM_IPINV: perm_data = des_ip_inv(in_data);
            PM_RSVD:  err_in    = 1'b1;
            default:  ;
        endcase
    end

`ifdef DES_PERM_PARITY_EN
    logic [0:7] par_in;

    always_comb begin
        par_in = '0;
        for (int b = 0; b < 8; b++) begin
            par_in[b] = ~^perm_data[8*b +: 8];
        end
    end

    assign pay[0] = {par_in, in_tag, err_in, perm_data};
    assign out_par = pay[PIPE_STAGES][65+TAG_W +: 8];
`else
    assign pay[0] = {in_tag, err_in, perm_data};
`endif

    assign v[0]             = in_valid;
    assign rdy[PIPE_STAGES] = out_ready;

    // Acceptance is blocked during flush and while reset is held.
    assign in_ready = rdy[0] && !flush && !rst;

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        des_perm_stage #(
            .W(PW)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .s_valid (v[k]),
            .s_ready (rdy[k]),
            .s_data  (pay[k]),
            .m_valid (v[k+1]),
            .m_ready (rdy[k+1]),
            .m_data  (pay[k+1])
        );
    end

    assign out_valid = v[PIPE_STAGES];
    assign out_data  = pay[PIPE_STAGES][63:0];
    assign out_err   = pay[PIPE_STAGES][64];
    assign out_tag   = pay[PIPE_STAGES][65 +: TAG_W];

endmodule

// File: tb/tb_des_perm_pipe.sv
// tb/tb_des_perm_pipe.sv - scoreboard bench for des_perm_pipe against a FIPS-table DES permutation model.
module tb_des_perm_pipe;

    localparam int PIPE_STAGES = 2;
    localparam int TAG_W       = 4;
    localparam int NFILL       = (PIPE_STAGES < 2) ? PIPE_STAGES : 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [0:63]      in_data;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [0:63]      out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
`ifdef DES_PERM_PARITY_EN
    logic [0:7]       out_par;
`endif

    always #5 clk = ~clk;

    des_perm_pipe #(
        .PIPE_STAGES(PIPE_STAGES),
        .TAG_W      (TAG_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_mode  (in_mode),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_tag  (out_tag),
        .out_err  (out_err)
`ifdef DES_PERM_PARITY_EN
        ,
        .out_par  (out_par)
`endif
    );

    typedef struct {
        logic [0:63]      d;
        logic [TAG_W-1:0] t;
        logic             e;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   ip_tbl[64];

    // FIPS 46-3 IP table: output bit j (1-based) takes input bit ip_tbl[j-1].
    function automatic logic [0:63] ref_ip(input logic [0:63] x);
        logic [0:63] y;
        for (int j = 0; j < 64; j++) y[j] = x[ip_tbl[j]-1];
        return y;
    endfunction

    function automatic logic [0:63] ref_ipinv(input logic [0:63] x);
        logic [0:63] y;
        for (int j = 0; j < 64; j++) y[ip_tbl[j]-1] = x[j];
        return y;
    endfunction

    function automatic logic [0:63] ref_model(input logic [1:0] m, input logic [0:63] x);
        if (m == 2'b01) return ref_ip(x);
        if (m == 2'b10) return ref_ipinv(x);
        return x;
    endfunction

    function automatic logic [0:7] ref_par(input logic [0:63] x);
        logic [0:7] p;
        for (int b = 0; b < 8; b++) p[b] = ($countones(x[8*b +: 8]) % 2 == 0);
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    logic [0:63]      pd;
    logic [TAG_W-1:0] pt;
    logic             pe;
    bit               pstall = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            pstall = 1'b0;
        end else begin
            if (pstall && out_valid) begin
                chk("stall_data", out_data, pd);
                chk("stall_tag", 64'(out_tag), 64'(pt));
                chk("stall_err", 64'(out_err), 64'(pe));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got data %h expected no beat", out_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("out_data", out_data, mon_e.d);
                    chk("out_tag", 64'(out_tag), 64'(mon_e.t));
                    chk("out_err", 64'(out_err), 64'(mon_e.e));
`ifdef DES_PERM_PARITY_EN
                    chk("out_par", 64'(out_par), 64'(ref_par(mon_e.d)));
`endif
                end
            end
            if (flush) sb.delete();
            pstall = out_valid && !out_ready && !flush;
            pd = out_data;
            pt = out_tag;
            pe = out_err;
        end
    end

    task automatic drive(input bit v, input logic [1:0] m, input logic [0:63] d,
                         input logic [TAG_W-1:0] t, input logic [0:63] ed,
                         input bit ordy, input bit fl, output bit acc);
        exp_t e;
        in_valid  = v;
        in_mode   = m;
        in_data   = d;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
        @(negedge clk);
        acc = in_valid && in_ready;
        if (acc) begin
            e.d = ed;
            e.t = t;
            e.e = (m == 2'b11);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic send(input logic [1:0] m, input logic [0:63] d, input logic [TAG_W-1:0] t,
                        input logic [0:63] ed, input bit ordy);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            drive(1'b1, m, d, t, ed, ordy, 1'b0, acc);
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got no acceptance expected acceptance within 100 cycles");
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        repeat (n) drive(1'b0, 2'b00, 64'h0, '0, 64'h0, ordy, 1'b0, acc);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            idle(1, 1'b1);
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bit          acc;
        int          n;
        int          cnt;
        logic [0:63] x;
        logic [1:0]  m;

        ip_tbl = '{58, 50, 42, 34, 26, 18, 10, 2,
                   60, 52, 44, 36, 28, 20, 12, 4,
                   62, 54, 46, 38, 30, 22, 14, 6,
                   64, 56, 48, 40, 32, 24, 16, 8,
                   57, 49, 41, 33, 25, 17,  9, 1,
                   59, 51, 43, 35, 27, 19, 11, 3,
                   61, 53, 45, 37, 29, 21, 13, 5,
                   63, 55, 47, 39, 31, 23, 15, 7};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 2'b00;
        in_data   = 64'h0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_err", 64'(out_err), 64'd0);
`ifdef DES_PERM_PARITY_EN
        chk("rst_out_par", 64'(out_par), 64'd0);
`endif
        rst = 1'b0;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Known-answer IP with latency measurement
        send(2'b01, 64'h0123456789ABCDEF, 4'h5, 64'hCC00CCFFF0AAF0AA, 1'b1);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("ip_latency", 64'(n), 64'(PIPE_STAGES));
        drain();

        send(2'b10, 64'hCC00CCFFF0AAF0AA, 4'hA, 64'h0123456789ABCDEF, 1'b1);
        drain();

        // Back-to-back beats, cycling modes, tags 0..15
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            m = 2'(i % 3);
            x = {$urandom, $urandom};
            drive(1'b1, m, x, 4'(i), ref_model(m, x), 1'b1, 1'b0, acc);
            if (!acc) cnt++;
            if (i >= PIPE_STAGES - 1) chk("b2b_out_valid", 64'(out_valid), 64'd1);
        end
        chk("b2b_all_accepted", 64'(cnt), 64'd0);
        drain();

        // Backpressure: only PIPE_STAGES beats fit while stalled
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            m = 2'($urandom_range(0, 3));
            x = {$urandom, $urandom};
            drive(1'b1, m, x, 4'(i), ref_model(m, x), 1'b0, 1'b0, acc);
            if (acc) cnt++;
        end
        chk("stall_accepted", 64'(cnt), 64'(PIPE_STAGES));
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        idle(3, 1'b0);
        drain();

        // Reserved mode passes data through with err set
        send(2'b11, 64'hFFFF0000FFFF0000, 4'h3, 64'hFFFF0000FFFF0000, 1'b1);
        drain();

        // Flush with beats in flight
        for (int i = 0; i < NFILL; i++) begin
            x = {$urandom, $urandom};
            send(2'b01, x, 4'(i), ref_ip(x), 1'b0);
        end
        drive(1'b1, 2'b00, 64'h1234, 4'hE, 64'h1234, 1'b0, 1'b1, acc);
        chk("flush_not_accepted", 64'(acc), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        x = {$urandom, $urandom};
        send(2'b10, x, 4'h9, ref_ipinv(x), 1'b1);
        drain();

`ifdef DES_PERM_PARITY_EN
        send(2'b00, 64'h0, 4'h1, 64'h0, 1'b1);
        drain();
`endif

        // IP followed by IP^-1 round trip
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom};
            send(2'b01, x, 4'(i), ref_ip(x), 1'b1);
            send(2'b10, ref_ip(x), 4'(i + 1), x, 1'b1);
        end
        drain();

        // Random valid, ready, mode and occasional flush
        for (int i = 0; i < 400; i++) begin
            m = 2'($urandom_range(0, 3));
            x = {$urandom, $urandom};
            drive(($urandom % 4) != 0, m, x, 4'($urandom), ref_model(m, x),
                  ($urandom % 4) != 0, ($urandom % 50) == 0, acc);
        end
        drain();

        // Reset mid-stream
        for (int i = 0; i < NFILL; i++) begin
            x = {$urandom, $urandom};
            send(2'b01, x, 4'(i), ref_ip(x), 1'b0);
        end
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", out_data, 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        x = {$urandom, $urandom};
        send(2'b01, x, 4'h6, ref_ip(x), 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
